sdram_frame_master: RTL
=======================

Name: sdram_frame_master

Overview:
- User-side initiator for the SDRAM controller's m_* request/ready interface.
- Buffers the camera pixel stream into a write FIFO and issues aligned write bursts into a single frame region.
- Refills a display read FIFO with aligned read bursts from the same region.
- Sits between the camera capture / display scan blocks and the SDRAM controller.

Parameters:
- BASE_ADDR, 24'h000000: first word address of the frame region, BURST_LEN-aligned.
- FRAME_WORDS, 307200: words per frame (640x480, RGB565); a multiple of BURST_LEN.
- BURST_LEN, 8: words per burst; a power of 2 that divides 512, so no burst crosses a row.
- FIFO_DEPTH, 32: depth of each FIFO; a power of 2, at least 2*BURST_LEN.

Ports:
- clk_ref  in  1  single clock, shared with the SDRAM controller.
- rst  in  1  asynchronous, active-high reset.
- px_data  in  16  camera pixel.
- px_valid  in  1  px_data valid this cycle.
- px_vsync  in  1  camera frame-start pulse.
- disp_vsync  in  1  display frame-start pulse.
- disp_rd  in  1  display pops one word.
- disp_data  out  16  popped word, registered, valid the cycle after disp_rd.
- m_addr  out  24  {bank[1:0], row[12:0], col[8:0]}.
- m_we  out  1  1 = write burst, 0 = read burst.
- m_valid  out  1  burst request; held for the whole burst.
- m_serial_access  out  1  keep the row open after this burst.
- m_ready  in  1  controller beat strobe.
- m_wdata  out  16  write FIFO head.
- m_rdata  in  16  read data, aligned with m_ready.
- wr_overflow  out  1  sticky; cleared on applied px_vsync.
- rd_underflow  out  1  sticky; cleared on applied disp_vsync.

Behaviour:
- Reset (async, rst=1):
  - m_valid=0, m_we=0, m_serial_access=0, m_addr=BASE_ADDR, disp_data=0.
  - wr_overflow=0, rd_underflow=0.
  - Both FIFOs empty; wr_ptr=rd_ptr=0 (word offsets into the region).
  - FSM in IDLE; all pending flags cleared.
- Beat rule: one word transfers on every cycle where m_valid && m_ready. A burst is exactly BURST_LEN beats.
- Burst end:
  - m_valid deasserts on the clock edge after the last beat.
  - At least one GAP cycle with m_valid=0 separates consecutive bursts.
- Request stability: m_addr and m_we stay stable while m_valid=1. m_addr = BASE_ADDR + pointer at burst start.
- FSM states: IDLE, WR_BURST, RD_BURST, GAP.
  - IDLE:
    - Apply pending vsyncs first.
    - If write FIFO level >= BURST_LEN: go to WR_BURST.
    - Else if read FIFO free >= BURST_LEN and rd_active: go to RD_BURST.
    - Writes have strict priority over reads.
  - WR_BURST:
    - m_we=1; m_wdata is the combinational FIFO head; pop on each beat.
    - After BURST_LEN beats: wr_ptr += BURST_LEN, wrapping to 0 at FRAME_WORDS. Go to GAP.
  - RD_BURST:
    - m_we=0; push m_rdata into the read FIFO on each beat.
    - After BURST_LEN beats: rd_ptr += BURST_LEN, same wrap. Go to GAP.
  - GAP: one cycle, then IDLE.
- m_serial_access:
  - Asserted during WR_BURST only if both hold: the next write address stays in the same row (next col != 0 and no frame wrap), and the write FIFO level excluding this burst is >= BURST_LEN at burst start.
  - Always 0 during reads.
- Write FIFO:
  - Push px_data when px_valid=1.
  - If full: drop the pixel and set wr_overflow.
  - A simultaneous push and pop while full is accepted (level unchanged).
- Read FIFO and display port:
  - rd_active is set by the first applied disp_vsync.
  - disp_rd while empty: disp_data=0 and rd_underflow set.
- Vsync handling:
  - A px_vsync or disp_vsync pulse sets a pending flag.
  - Pending flags are applied only in IDLE, never mid-burst.
  - px_vsync applied: flush write FIFO, wr_ptr=0, clear wr_overflow.
  - disp_vsync applied: flush read FIFO, rd_ptr=0, clear rd_underflow.
  - Pixels arriving while px_vsync is pending are dropped and do not set overflow.
- Mid-burst reset: bus idles immediately (m_valid=0); the controller tolerates m_valid falling.

Test Plan:
- Reset, then 8 px_valid words 0x0001..0x0008 with m_ready tied 1 -> one burst: m_addr=BASE_ADDR, m_we=1, m_wdata sequence 1..8, m_valid high exactly 8 cycles, wr_ptr=8.
- Stream 48 pixels with m_ready=0 -> FIFO fills at 32; wr_overflow=1; the last 16 pixels are lost; m_valid stays high, no beats.
- Write a full frame, wrapping at FRAME_WORDS=64 (test override) -> burst 9 uses m_addr=BASE_ADDR. m_serial_access=0 on the burst ending at col 511 and on the wrap burst.
- disp_vsync, then m_ready pulses with m_rdata=0xA000+n -> read FIFO fills to 32 in 4 bursts; disp_rd returns 0xA000.. in order, one cycle later.
- Write FIFO at 8 and read FIFO free simultaneously -> write burst issued first, GAP, then read burst.
- px_vsync mid-WR_BURST -> burst completes all 8 beats; then FIFO flushed and next write m_addr=BASE_ADDR. Async rst mid-burst -> m_valid=0 in the same cycle.

Source files
------------

// File: rtl/sdram_frame_master_if.sv
// Request/ready bus between the frame master and the SDRAM controller.
// The master drives the burst request; the controller strobes beats with m_ready.
interface sdram_frame_master_if;
    logic [23:0] m_addr;
    logic        m_we;
    logic        m_valid;
    logic        m_serial_access;
    logic        m_ready;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;

    modport master (
        output m_addr, m_we, m_valid, m_serial_access, m_wdata,
        input  m_ready, m_rdata
    );

    modport slave (
        input  m_addr, m_we, m_valid, m_serial_access, m_wdata,
        output m_ready, m_rdata
    );
endinterface

// File: rtl/sdram_frame_master.sv
// Camera-to-SDRAM write bursts and SDRAM-to-display read bursts over one
// frame region, each side decoupled by a small FIFO.
module sdram_frame_master #(
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int          FRAME_WORDS = 307200,
    parameter int          BURST_LEN   = 8,
    parameter int          FIFO_DEPTH  = 32
) (
    input  logic        clk_ref,
    input  logic        rst,
    input  logic [15:0] px_data,
    input  logic        px_valid,
    input  logic        px_vsync,
    input  logic        disp_vsync,
    input  logic        disp_rd,
    output logic [15:0] disp_data,
    output logic        wr_overflow,
    output logic        rd_underflow,
    sdram_frame_master_if.master m
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BURST_LEN);
    localparam logic [AW:0]   DEPTH   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   BL_LVL  = (AW+1)'(BURST_LEN);
    localparam logic [AW:0]   BL2_LVL = (AW+1)'(2*BURST_LEN);
    localparam logic [AW:0]   P1      = (AW+1)'(1);
    localparam logic [BW-1:0] B1      = BW'(1);
    localparam logic [BW-1:0] LAST    = BW'(BURST_LEN-1);
    localparam logic [23:0]   BL_W    = 24'(BURST_LEN);
    localparam logic [23:0]   FW      = 24'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, GAP} state_t;

    state_t        state, state_nx;
    logic [BW-1:0] beat_cnt;
    logic [23:0]   addr_q, wr_ptr, rd_ptr;
    logic          ser_q, px_pend, disp_pend, rd_active;

    logic [15:0] wf_mem [FIFO_DEPTH];
    logic [15:0] rf_mem [FIFO_DEPTH];
    logic [AW:0] wf_wp, wf_rp, rf_wp, rf_rp;

    logic        bus_valid, beat, last;
    logic        apply_px, apply_disp;
    logic        start_wr, start_rd, wr_done, rd_done;
    logic [AW:0] wf_lvl, rf_lvl, rf_free;
    logic        wf_full, wf_push, wf_pop, rf_empty, rf_push, rf_pop;
    logic [23:0] wr_sum, rd_sum;
    logic [8:0]  nxt_col;
    logic        wr_same_row;

    assign bus_valid = (state == WR_BURST) || (state == RD_BURST);
    assign beat      = bus_valid && m.m_ready;
    assign last      = beat && (beat_cnt == LAST);

    assign apply_px   = (state == IDLE) && px_pend;
    assign apply_disp = (state == IDLE) && disp_pend;
    assign start_wr   = (state == IDLE) && (state_nx == WR_BURST);
    assign start_rd   = (state == IDLE) && (state_nx == RD_BURST);
    assign wr_done    = (state == WR_BURST) && last;
    assign rd_done    = (state == RD_BURST) && last;

    assign wf_lvl   = wf_wp - wf_rp;
    assign wf_full  = (wf_lvl == DEPTH);
    assign wf_pop   = beat && (state == WR_BURST);
    // A pixel landing on a full FIFO still fits when a beat frees a slot.
    assign wf_push  = px_valid && !px_pend && (!wf_full || wf_pop);
    assign rf_lvl   = rf_wp - rf_rp;
    assign rf_free  = DEPTH - rf_lvl;
    assign rf_empty = (rf_wp == rf_rp);
    assign rf_push  = beat && (state == RD_BURST);
    assign rf_pop   = disp_rd && !rf_empty;

    assign wr_sum      = wr_ptr + BL_W;
    assign rd_sum      = rd_ptr + BL_W;
    assign nxt_col     = BASE_ADDR[8:0] + wr_ptr[8:0] + BL_W[8:0];
    assign wr_same_row = (wr_sum != FW) && (nxt_col != 9'd0);

    assign m.m_valid         = bus_valid;
    assign m.m_we            = (state == WR_BURST);
    assign m.m_serial_access = ser_q && (state == WR_BURST);
    assign m.m_addr          = addr_q;
    assign m.m_wdata         = wf_mem[wf_rp[AW-1:0]];

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                // Frame restarts take the whole cycle; bursts wait one more.
                if (!px_pend && !disp_pend) begin
                    if (wf_lvl >= BL_LVL)
                        state_nx = WR_BURST;
                    else if (rd_active && rf_free >= BL_LVL)
                        state_nx = RD_BURST;
                end
            end
            WR_BURST: if (last) state_nx = GAP;
            RD_BURST: if (last) state_nx = GAP;
            GAP:      state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_ref) begin
        if (wf_push) wf_mem[wf_wp[AW-1:0]] <= px_data;
        if (rf_push) rf_mem[rf_wp[AW-1:0]] <= m.m_rdata;
    end

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            addr_q       <= BASE_ADDR;
            ser_q        <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            px_pend      <= 1'b0;
            disp_pend    <= 1'b0;
            rd_active    <= 1'b0;
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
            wf_wp        <= '0;
            wf_rp        <= '0;
            rf_wp        <= '0;
            rf_rp        <= '0;
            disp_data    <= '0;
        end else begin
            state     <= state_nx;
            px_pend   <= (px_pend && !apply_px) || px_vsync;
            disp_pend <= (disp_pend && !apply_disp) || disp_vsync;
            if (beat) beat_cnt <= beat_cnt + B1;
            if (apply_disp) rd_active <= 1'b1;

            if (start_wr) begin
                addr_q <= BASE_ADDR + wr_ptr;
                ser_q  <= wr_same_row && (wf_lvl >= BL2_LVL);
            end else if (start_rd) begin
                addr_q <= BASE_ADDR + rd_ptr;
                ser_q  <= 1'b0;
            end

            if (apply_px)
                wr_ptr <= '0;
            else if (wr_done)
                wr_ptr <= (wr_sum == FW) ? '0 : wr_sum;
            if (apply_disp)
                rd_ptr <= '0;
            else if (rd_done)
                rd_ptr <= (rd_sum == FW) ? '0 : rd_sum;

            if (wf_push) wf_wp <= wf_wp + P1;
            if (apply_px)
                wf_rp <= wf_wp;
            else if (wf_pop)
                wf_rp <= wf_rp + P1;
            if (apply_px)
                wr_overflow <= 1'b0;
            else if (px_valid && !px_pend && wf_full && !wf_pop)
                wr_overflow <= 1'b1;

            if (rf_push) rf_wp <= rf_wp + P1;
            if (apply_disp)
                rf_rp <= rf_wp;
            else if (rf_pop)
                rf_rp <= rf_rp + P1;
            if (disp_rd)
                disp_data <= rf_empty ? 16'h0000 : rf_mem[rf_rp[AW-1:0]];
            if (apply_disp)
                rd_underflow <= 1'b0;
            else if (disp_rd && rf_empty)
                rd_underflow <= 1'b1;
        end
    end
endmodule
